// File: rtl/mem_arbiter.sv
// Two-core memory arbiter: class priority write > data read > instruction read,
// per-class round-robin between cores, and a starvation override for instruction fetches.
module mem_arbiter #(
   parameter int unsigned CPUS         = 2,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic [CPUS-1:0]      iREN,
   input  logic [CPUS*32-1:0]   iaddr,
   input  logic [CPUS-1:0]      dREN,
   input  logic [CPUS-1:0]      dWEN,
   input  logic [CPUS*32-1:0]   daddr,
   input  logic [CPUS*32-1:0]   dstore,
   output logic [CPUS-1:0]      iwait,
   output logic [CPUS-1:0]      dwait,
   output logic [CPUS*32-1:0]   iload,
   output logic [CPUS*32-1:0]   dload,
   output logic                 ramREN,
   output logic                 ramWEN,
   output logic [31:0]          ramaddr,
   output logic [31:0]          ramstore,
   input  logic [31:0]          ramload,
   input  logic [1:0]           ramstate
);

   // ramstate encoding: FREE=0, BUSY=1, ACCESS=2, ERROR=3
   localparam logic [1:0] RAM_ACCESS = 2'd2;
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   typedef enum logic {StIdle, StServe} state_t;
   typedef enum logic [1:0] {ClsWrite, ClsRead, ClsInstr} cls_t;

   state_t           r_state, w_state_next;
   cls_t             r_cls, w_cls_next, w_win_cls;
   logic             r_core, w_core_next, w_win_core;
   logic [2:0]       r_ptr, w_ptr_next;   // one bit per class: core favoured on the next tie
   logic [CNT_W-1:0] r_starve, w_starve_next;

   logic [CPUS-1:0]  w_wr_req, w_rd_req, w_win_req;
   logic             w_win_ptr, w_any_req, w_starved, w_active, w_done;
   logic [31:0]      w_iaddr_g, w_daddr_g, w_dstore_g;

   // A core asserting both dREN and dWEN is treated as a write
   assign w_wr_req  = dWEN;
   assign w_rd_req  = dREN & ~dWEN;
   assign w_any_req = (|dWEN) | (|dREN) | (|iREN);
   assign w_starved = (r_starve == STARVE_MAX) && (iREN != '0);

   assign w_iaddr_g  = r_core ? iaddr[63:32]  : iaddr[31:0];
   assign w_daddr_g  = r_core ? daddr[63:32]  : daddr[31:0];
   assign w_dstore_g = r_core ? dstore[63:32] : dstore[31:0];

   // Winner selection, only consumed in StIdle
   always_comb begin
      w_win_cls = ClsInstr;
      w_win_req = iREN;
      w_win_ptr = r_ptr[2];
      if (!w_starved) begin
         if (|w_wr_req) begin
            w_win_cls = ClsWrite;
            w_win_req = w_wr_req;
            w_win_ptr = r_ptr[0];
         end else if (|w_rd_req) begin
            w_win_cls = ClsRead;
            w_win_req = w_rd_req;
            w_win_ptr = r_ptr[1];
         end
      end
      w_win_core = w_win_req[w_win_ptr] ? w_win_ptr : ~w_win_ptr;
   end

   always_comb begin
      unique case (r_cls)
         ClsWrite: w_active = dWEN[r_core];
         ClsRead:  w_active = dREN[r_core];
         default:  w_active = iREN[r_core];
      endcase
   end

   always_comb begin
      w_state_next = r_state;
      w_cls_next   = r_cls;
      w_core_next  = r_core;
      w_ptr_next   = r_ptr;
      w_done       = 1'b0;
      iwait        = '1;
      dwait        = '1;
      iload        = '0;
      dload        = '0;
      ramREN       = 1'b0;
      ramWEN       = 1'b0;
      ramaddr      = '0;
      ramstore     = '0;
      unique case (r_state)
         StIdle: begin
            if (w_any_req) begin
               w_state_next = StServe;
               w_cls_next   = w_win_cls;
               w_core_next  = w_win_core;
            end
         end
         StServe: begin
            // A withdrawn grant abandons the transfer without a completion pulse
            if (!w_active) begin
               w_state_next = StIdle;
            end else begin
               unique case (r_cls)
                  ClsWrite: begin
                     ramWEN   = 1'b1;
                     ramaddr  = w_daddr_g;
                     ramstore = w_dstore_g;
                  end
                  ClsRead: begin
                     ramREN  = 1'b1;
                     ramaddr = w_daddr_g;
                  end
                  default: begin
                     ramREN  = 1'b1;
                     ramaddr = w_iaddr_g;
                  end
               endcase
               if (ramstate == RAM_ACCESS) begin
                  w_done       = 1'b1;
                  w_state_next = StIdle;
                  unique case (r_cls)
                     ClsWrite: begin
                        dwait[r_core] = 1'b0;
                        w_ptr_next[0] = ~r_core;
                     end
                     ClsRead: begin
                        dwait[r_core] = 1'b0;
                        w_ptr_next[1] = ~r_core;
                        if (r_core) dload[63:32] = ramload;
                        else        dload[31:0]  = ramload;
                     end
                     default: begin
                        iwait[r_core] = 1'b0;
                        w_ptr_next[2] = ~r_core;
                        if (r_core) iload[63:32] = ramload;
                        else        iload[31:0]  = ramload;
                     end
                  endcase
               end
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   // Consecutive data completions while a fetch waits; saturates at the limit
   always_comb begin
      w_starve_next = r_starve;
      if (iREN == '0) begin
         w_starve_next = '0;
      end else if (w_done) begin
         if (r_cls == ClsInstr) begin
            w_starve_next = '0;
         end else if (r_starve != STARVE_MAX) begin
            w_starve_next = r_starve + 1'b1;
         end
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state  <= StIdle;
         r_cls    <= ClsWrite;
         r_core   <= 1'b0;
         r_ptr    <= '0;
         r_starve <= '0;
      end else begin
         r_state  <= w_state_next;
         r_cls    <= w_cls_next;
         r_core   <= w_core_next;
         r_ptr    <= w_ptr_next;
         r_starve <= w_starve_next;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked against a cycle-level
// reference model built from the arbitration rules.
module tb_mem_arbiter;

   localparam int LIMIT = 4;
   localparam logic [1:0] RAM_FREE = 2'd0, RAM_BUSY = 2'd1, RAM_ACCESS = 2'd2, RAM_ERROR = 2'd3;

   logic        CLK = 1'b0;
   logic        nRST;
   logic [1:0]  iREN, dREN, dWEN, iwait, dwait;
   logic [63:0] iaddr, daddr, dstore, iload, dload;
   logic        ramREN, ramWEN;
   logic [31:0] ramaddr, ramstore, ramload;
   logic [1:0]  ramstate;

   mem_arbiter #(.CPUS(2), .STARVE_LIMIT(LIMIT)) dut (
      .CLK(CLK), .nRST(nRST), .iREN(iREN), .iaddr(iaddr), .dREN(dREN), .dWEN(dWEN),
      .daddr(daddr), .dstore(dstore), .iwait(iwait), .dwait(dwait), .iload(iload),
      .dload(dload), .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
      .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_pass = 0;

   // Reference model: busy flag, granted (class, core), per-class favoured core, counter.
   // Class codes: 0 write, 1 data read, 2 instruction read.
   int m_busy, m_core, m_cls, m_starve;
   int m_ptr[3];
   logic [1:0]  e_iwait, e_dwait;
   logic [63:0] e_iload, e_dload;
   logic        e_ren, e_wen;
   logic [31:0] e_addr, e_store;
   bit e_done, e_held;

   int log_q[$];   // observed completions, code = class*2 + core
   bit auto_drop;
   logic [1:0] last_dwait;
   logic last_ren;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] word(input logic [63:0] bus, input int c);
      return (c != 0) ? bus[63:32] : bus[31:0];
   endfunction

   function automatic int log_at(input int i);
      return (i < log_q.size()) ? log_q[i] : 99;
   endfunction

   task automatic model_reset();
      m_busy = 0; m_core = 0; m_cls = 0; m_starve = 0;
      for (int c = 0; c < 3; c++) m_ptr[c] = 0;
   endtask

   task automatic model_outputs();
      e_iwait = 2'b11; e_dwait = 2'b11; e_iload = '0; e_dload = '0;
      e_ren = 1'b0; e_wen = 1'b0; e_addr = '0; e_store = '0;
      e_done = 1'b0; e_held = 1'b0;
      if (m_busy != 0 && nRST) begin
         e_held = (m_cls == 0) ? dWEN[m_core] : (m_cls == 1) ? dREN[m_core] : iREN[m_core];
         if (e_held) begin
            e_addr = (m_cls == 2) ? word(iaddr, m_core) : word(daddr, m_core);
            if (m_cls == 0) begin
               e_wen = 1'b1;
               e_store = word(dstore, m_core);
            end else begin
               e_ren = 1'b1;
            end
            if (ramstate == RAM_ACCESS) begin
               e_done = 1'b1;
               if (m_cls == 2) begin
                  e_iwait[m_core] = 1'b0;
                  e_iload[32*m_core +: 32] = ramload;
               end else begin
                  e_dwait[m_core] = 1'b0;
                  if (m_cls == 1) e_dload[32*m_core +: 32] = ramload;
               end
            end
         end
      end
   endtask

   task automatic model_next();
      int ns;
      int pick;
      logic [1:0] req [3];
      if (!nRST) begin
         model_reset();
         return;
      end
      if (iREN == 2'b00) ns = 0;
      else if (e_done) ns = (m_cls == 2) ? 0 : ((m_starve + 1 > LIMIT) ? LIMIT : m_starve + 1);
      else ns = m_starve;
      if (m_busy != 0) begin
         if (e_done) m_ptr[m_cls] = 1 - m_core;
         if (e_done || !e_held) m_busy = 0;
      end else begin
         req[0] = dWEN; req[1] = dREN & ~dWEN; req[2] = iREN;
         pick = -1;
         if (m_starve >= LIMIT && iREN != 2'b00) pick = 2;
         else for (int c = 0; c < 3; c++) if (pick < 0 && req[c] != 2'b00) pick = c;
         if (pick >= 0) begin
            m_busy = 1;
            m_cls = pick;
            m_core = req[pick][m_ptr[pick]] ? m_ptr[pick] : 1 - m_ptr[pick];
         end
      end
      m_starve = ns;
   endtask

   task automatic tick();
      int d_cls, d_core;
      bit d_done;
      iaddr = {$urandom, $urandom}; daddr = {$urandom, $urandom};
      dstore = {$urandom, $urandom}; ramload = $urandom;
      @(negedge CLK);
      model_outputs();
      check("iwait", 64'(iwait), 64'(e_iwait));
      check("dwait", 64'(dwait), 64'(e_dwait));
      check("iload", iload, e_iload);
      check("dload", dload, e_dload);
      check("ramREN", 64'(ramREN), 64'(e_ren));
      check("ramWEN", 64'(ramWEN), 64'(e_wen));
      check("ramaddr", 64'(ramaddr), 64'(e_addr));
      check("ramstore", 64'(ramstore), 64'(e_store));
      for (int c = 0; c < 2; c++) begin
         if (dwait[c] == 1'b0) log_q.push_back(ramWEN ? c : 2 + c);
         if (iwait[c] == 1'b0) log_q.push_back(4 + c);
      end
      last_dwait = dwait; last_ren = ramREN;
      d_cls = m_cls; d_core = m_core; d_done = e_done;
      model_next();
      @(posedge CLK);
      #1;
      if (auto_drop && d_done) begin
         if (d_cls == 0) dWEN[d_core] = 1'b0;
         else if (d_cls == 1) dREN[d_core] = 1'b0;
         else iREN[d_core] = 1'b0;
      end
   endtask

   task automatic do_reset();
      nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ramstate = RAM_FREE;
      tick();
      nRST = 1'b1;
      log_q.delete();
   endtask

   initial begin
      int pulses, pulse_at, ren_cnt, r;
      int exp_prio[4] = '{0, 3, 4, 5};
      int exp_starve[5] = '{0, 0, 0, 0, 5};
      nRST = 1'b0; iREN = '0; dREN = '0; dWEN = '0; ramstate = RAM_FREE;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; auto_drop = 1'b0;
      model_reset();
      #1;
      check("rst_iwait", 64'(iwait), 64'(2'b11));
      check("rst_dwait", 64'(dwait), 64'(2'b11));
      check("rst_strobes", 64'({ramREN, ramWEN}), 64'(0));
      @(posedge CLK);
      #1;

      // Class priority, each request withdrawn once served
      do_reset(); auto_drop = 1'b1;
      dWEN = 2'b01; dREN = 2'b10; iREN = 2'b11; ramstate = RAM_ACCESS;
      repeat (10) tick();
      check("prio_count", 64'(log_q.size()), 64'(4));
      for (int i = 0; i < 4; i++) check("prio_order", 64'(log_at(i)), 64'(exp_prio[i]));

      // Round-robin between two continuous data readers
      do_reset(); auto_drop = 1'b0;
      dREN = 2'b11; ramstate = RAM_ACCESS;
      repeat (12) tick();
      for (int i = 0; i < 6; i++) check("rr_order", 64'(log_at(i)), 64'(2 + (i % 2)));

      // Starvation override
      do_reset(); auto_drop = 1'b0;
      dWEN = 2'b01; iREN = 2'b10; ramstate = RAM_ACCESS;
      repeat (10) tick();
      for (int i = 0; i < 5; i++) check("starve_order", 64'(log_at(i)), 64'(exp_starve[i]));

      // Latency with three BUSY cycles
      do_reset(); auto_drop = 1'b1;
      dREN = 2'b01; pulses = 0; pulse_at = -1; ren_cnt = 0;
      for (int i = 0; i < 7; i++) begin
         ramstate = (i == 4) ? RAM_ACCESS : RAM_BUSY;
         tick();
         if (last_dwait[0] == 1'b0) begin pulses++; pulse_at = i; end
         if (last_ren) ren_cnt++;
      end
      check("lat_pulses", 64'(pulses), 64'(1));
      check("lat_cycle", 64'(pulse_at), 64'(4));
      check("lat_ren_cycles", 64'(ren_cnt), 64'(4));

      // Abort: core1 withdraws during BUSY, pointer keeps favouring core1
      do_reset(); auto_drop = 1'b1;
      dREN = 2'b01; ramstate = RAM_ACCESS;
      tick(); tick();
      log_q.delete();
      dREN = 2'b10; ramstate = RAM_BUSY;
      tick(); tick();
      dREN = 2'b00;
      tick();
      check("abort_no_pulse", 64'(log_q.size()), 64'(0));
      dREN = 2'b11; ramstate = RAM_ACCESS;
      tick(); tick();
      check("abort_rr_core1", 64'(log_at(0)), 64'(3));

      // Reset mid-SERVE
      do_reset(); auto_drop = 1'b0;
      dREN = 2'b10; ramstate = RAM_BUSY;
      tick(); tick();
      check("rst_pre_serve", 64'(last_ren), 64'(1));
      log_q.delete();
      nRST = 1'b0;
      #1;
      check("rst_mid_waits", 64'({iwait, dwait}), 64'(4'b1111));
      check("rst_mid_loads", iload | dload, 64'(0));
      check("rst_mid_strobes", 64'({ramREN, ramWEN}), 64'(0));
      check("rst_mid_bus", 64'({ramaddr, ramstore}), 64'(0));
      ramstate = RAM_ACCESS;
      tick();
      nRST = 1'b1; dREN = 2'b00; iREN = 2'b11; auto_drop = 1'b1;
      repeat (5) tick();
      check("rst_after_count", 64'(log_q.size()), 64'(2));
      check("rst_after_first", 64'(log_at(0)), 64'(4));
      check("rst_after_second", 64'(log_at(1)), 64'(5));

      // Randomized traffic with occasional resets
      do_reset(); auto_drop = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if ($urandom_range(3) == 0) begin
            iREN = 2'($urandom);
            dREN = 2'($urandom);
            dWEN = ($urandom_range(2) == 0) ? 2'($urandom) : 2'b00;
         end
         r = $urandom_range(7);
         ramstate = (r == 0) ? RAM_FREE : (r == 1) ? RAM_BUSY : (r == 2) ? RAM_ERROR : RAM_ACCESS;
         nRST = ($urandom_range(99) != 0);
         tick();
      end
      nRST = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
